// File: rtl/unary_mm_sequencer.sv
// rtl/unary_mm_sequencer.sv - job sequencer for a unary matrix-multiply row/column counter-array pair
//
// Purpose: accepts a job of N row/column vector pairs, fetches each pair from upstream,
// strobes the counter-array saves, enables counting until the row array reports done,
// drives accumulator clear/enable, bounds every run with a watchdog and hands the result
// downstream.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   start_valid/start_ready    job request handshake; num_vec sampled on acceptance
//   num_vec                    job length N (clamped to MAX_VEC)
//   abort                      synchronous abort back to IDLE
//   vec_valid/vec_ready        upstream vector-pair handshake
//   row_save, col_save         save strobes to the row / column counter arrays
//   cnt_en                     count enable to both arrays
//   row_done, lane_busy        status from the row array (lane_busy is informational)
//   acc_clear, acc_en          downstream accumulator control
//   vec_idx                    index of the pair in flight
//   out_valid/out_ready        job-complete handshake
//   err                        watchdog fired during the current/last job
//   run_cycles                 RUN cycles spent in the last job (saturating)

module unary_mm_sequencer #(
    parameter int DIM     = 4,
    parameter int WIDTH   = 8,
    parameter int MAX_VEC = 16,
    parameter int CYC_W   = 16,
    parameter int VEC_W   = $clog2(MAX_VEC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [VEC_W-1:0] num_vec,
    input  logic             abort,
    input  logic             vec_valid,
    output logic             vec_ready,
    output logic             row_save,
    output logic             col_save,
    output logic             cnt_en,
    input  logic             row_done,
    input  logic [DIM-1:0]   lane_busy,
    output logic             acc_clear,
    output logic             acc_en,
    output logic [VEC_W-1:0] vec_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CYC_W-1:0] run_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int WD_W = WIDTH + 1;
    // wd value seen on the last RUN cycle a legal pair may need (max magnitude 2^(WIDTH-1)
    // takes 2^(WIDTH-1)+1 cycles); reaching it without row_done means the array is stuck.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(1) << (WIDTH - 1);
    localparam logic [VEC_W-1:0] VEC_MAX  = VEC_W'(MAX_VEC);
    localparam logic [CYC_W-1:0] CYC_SAT  = {CYC_W{1'b1}};

    state_t           state_q, state_d;
    logic [VEC_W-1:0] num_q, num_d;
    logic [VEC_W-1:0] vec_idx_q, vec_idx_d;
    logic             err_q, err_d;
    logic [CYC_W-1:0] run_cycles_q, run_cycles_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             first_q, first_d;
    logic [VEC_W-1:0] num_clamped;

    // lane_busy carries no control meaning here; it is kept on the port for observability.
    logic unused_lane_busy;
    assign unused_lane_busy = ^lane_busy;

    assign num_clamped = (num_vec > VEC_MAX) ? VEC_MAX : num_vec;

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        vec_idx_d    = vec_idx_q;
        err_d        = err_q;
        run_cycles_d = run_cycles_q;
        wd_d         = wd_q;
        first_d      = first_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        num_d        = num_clamped;
                        vec_idx_d    = '0;
                        err_d        = 1'b0;
                        run_cycles_d = '0;
                        wd_d         = '0;
                        first_d      = 1'b1;
                        state_d      = (num_clamped == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    // acc_clear covers only the very first LOAD cycle, even if upstream stalls.
                    first_d = 1'b0;
                    wd_d    = '0;
                    if (vec_valid) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_cycles_q != CYC_SAT) begin
                        run_cycles_d = run_cycles_q + CYC_W'(1);
                    end
                    wd_d = wd_q + WD_W'(1);
                    // row_done is checked first so it wins over a simultaneous watchdog expiry.
                    if (row_done) begin
                        wd_d = '0;
                        if (vec_idx_q == num_q - VEC_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            vec_idx_d = vec_idx_q + VEC_W'(1);
                            state_d   = S_LOAD;
                        end
                    end else if (wd_q == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            vec_idx_q    <= '0;
            err_q        <= 1'b0;
            run_cycles_q <= '0;
            wd_q         <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            vec_idx_q    <= vec_idx_d;
            err_q        <= err_d;
            run_cycles_q <= run_cycles_d;
            wd_q         <= wd_d;
            first_q      <= first_d;
        end
    end

    // Moore decode of the registered state; only the save strobes follow vec_valid directly
    // so the arrays capture the pair in the same cycle as the handshake.
    assign start_ready = (state_q == S_IDLE);
    assign vec_ready   = (state_q == S_LOAD);
    assign cnt_en      = (state_q == S_RUN);
    assign acc_en      = (state_q == S_RUN);
    assign acc_clear   = (state_q == S_LOAD) && first_q;
    assign out_valid   = (state_q == S_DONE);
    assign row_save    = (state_q == S_LOAD) && vec_valid && !abort;
    assign col_save    = (state_q == S_LOAD) && vec_valid && !abort;
    assign vec_idx     = vec_idx_q;
    assign err         = err_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_unary_mm_sequencer.sv
// tb/tb_unary_mm_sequencer.sv - directed self-checking bench for unary_mm_sequencer

module tb_unary_mm_sequencer;

    localparam int DIM     = 4;
    localparam int WIDTH   = 8;
    localparam int MAX_VEC = 16;
    localparam int CYC_W   = 16;
    localparam int VEC_W   = $clog2(MAX_VEC + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic [VEC_W-1:0] num_vec;
    logic             abort;
    logic             vec_valid;
    logic             vec_ready;
    logic             row_save;
    logic             col_save;
    logic             cnt_en;
    logic             row_done;
    logic [DIM-1:0]   lane_busy;
    logic             acc_clear;
    logic             acc_en;
    logic [VEC_W-1:0] vec_idx;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CYC_W-1:0] run_cycles;

    always #5 clk = ~clk;

    unary_mm_sequencer #(
        .DIM(DIM), .WIDTH(WIDTH), .MAX_VEC(MAX_VEC), .CYC_W(CYC_W), .VEC_W(VEC_W)
    ) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready), .num_vec(num_vec),
        .abort(abort),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .row_save(row_save), .col_save(col_save), .cnt_en(cnt_en),
        .row_done(row_done), .lane_busy(lane_busy),
        .acc_clear(acc_clear), .acc_en(acc_en), .vec_idx(vec_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .run_cycles(run_cycles)
    );

    // Row-array model: loads the pair's max magnitude on save, counts down while enabled.
    int mags [MAX_VEC];
    int row_cnt;
    bit tie0 = 1'b0;

    assign row_done  = !tie0 && (row_cnt == 0);
    assign lane_busy = (row_cnt != 0) ? {DIM{1'b1}} : {DIM{1'b0}};

    always @(posedge clk or posedge reset) begin
        if (reset)                        row_cnt <= 0;
        else if (row_save)                row_cnt <= mags[vec_idx];
        else if (cnt_en && row_cnt != 0)  row_cnt <= row_cnt - 1;
    end

    // Event counters sampled mid-cycle, when inputs and state are both settled.
    int n_save, n_colsave, n_cnt, n_acc, n_clear, n_ov, n_stall;
    int save_idx [$];

    always @(negedge clk) begin
        if (row_save) begin
            n_save++;
            save_idx.push_back(int'(vec_idx));
        end
        if (col_save)               n_colsave++;
        if (cnt_en)                 n_cnt++;
        if (acc_en)                 n_acc++;
        if (acc_clear)              n_clear++;
        if (out_valid)              n_ov++;
        if (vec_ready && !vec_valid) n_stall++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    bit abort_hit;
    bit reset_hit;

    task automatic run_job(input int n, input int stall_idx, input int stall_len, input int hold,
                           input bit do_abort, input bit do_reset, output int lat);
        int stall_left;
        int hold_left;
        bit fin;
        bit aborted;
        stall_left = stall_len;
        hold_left  = hold;
        fin        = 1'b0;
        aborted    = 1'b0;
        lat        = -1;
        abort_hit  = 1'b0;
        reset_hit  = 1'b0;
        n_save = 0; n_colsave = 0; n_cnt = 0; n_acc = 0; n_clear = 0; n_ov = 0; n_stall = 0;
        save_idx.delete();

        @(posedge clk); #1;
        start_valid = 1'b1;
        num_vec     = VEC_W'(n);
        vec_valid   = 1'b0;
        out_ready   = 1'b0;
        abort       = 1'b0;

        for (int i = 0; i < 400 && !fin; i++) begin
            @(posedge clk); #1;
            start_valid = 1'b0;
            abort       = 1'b0;
            if (aborted) begin
                fin = start_ready;
            end else if (do_reset && cnt_en && vec_idx == VEC_W'(2)) begin
                reset     = 1'b1;
                vec_valid = 1'b0;
                reset_hit = 1'b1;
                @(negedge clk);
                check_eq("rst_start_ready", start_ready, 1);
                check_eq("rst_strobes", {row_save, col_save, cnt_en, acc_en, acc_clear, vec_ready, out_valid}, 0);
                check_eq("rst_err", err, 0);
                check_eq("rst_vec_idx", vec_idx, 0);
                check_eq("rst_run_cycles", run_cycles, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                fin   = 1'b1;
            end else if (do_abort && cnt_en && row_done && vec_idx == VEC_W'(n - 1)) begin
                abort     = 1'b1;
                aborted   = 1'b1;
                abort_hit = 1'b1;
                vec_valid = 1'b0;
            end else begin
                if (vec_ready && int'(vec_idx) == stall_idx && stall_left > 0) begin
                    vec_valid = 1'b0;
                    stall_left--;
                end else begin
                    vec_valid = vec_ready;
                end
                if (out_valid) begin
                    if (lat < 0) lat = i + 1;
                    if (hold_left > 0) begin
                        out_ready = 1'b0;
                        hold_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end else if (lat >= 0) begin
                    out_ready = 1'b0;
                    fin       = 1'b1;
                end
            end
        end
        check_eq("job_finished", fin, 1);
        vec_valid = 1'b0;
        out_ready = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int lat;

    initial begin
        reset = 1'b1; start_valid = 1'b0; num_vec = '0; abort = 1'b0;
        vec_valid = 1'b0; out_ready = 1'b0;
        foreach (mags[i]) mags[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_start_ready", start_ready, 1);
        check_eq("reset_strobes", {vec_ready, out_valid, cnt_en, acc_en, acc_clear}, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_run_cycles", run_cycles, 0);
        check_eq("reset_vec_idx", vec_idx, 0);
        reset = 1'b0;

        // N=1, max|v|=3
        mags[0] = 3;
        run_job(1, -1, 0, 0, 0, 0, lat);
        check_eq("n1_saves", n_save, 1);
        check_eq("n1_colsaves", n_colsave, 1);
        check_eq("n1_cnt_en", n_cnt, 4);
        check_eq("n1_acc_en", n_acc, 4);
        check_eq("n1_run_cycles", run_cycles, 4);
        check_eq("n1_out_valid", n_ov, 1);
        check_eq("n1_acc_clear", n_clear, 1);
        check_eq("n1_err", err, 0);

        // N=3, upstream stalls 5 cycles before pair 2
        mags[0] = 2; mags[1] = 0; mags[2] = 1;
        run_job(3, 2, 5, 0, 0, 0, lat);
        check_eq("n3_saves", n_save, 3);
        check_eq("n3_stall_cycles", n_stall, 5);
        check_eq("n3_idx0", (save_idx.size() > 0) ? save_idx[0] : -1, 0);
        check_eq("n3_idx1", (save_idx.size() > 1) ? save_idx[1] : -1, 1);
        check_eq("n3_idx2", (save_idx.size() > 2) ? save_idx[2] : -1, 2);
        check_eq("n3_acc_clear", n_clear, 1);
        check_eq("n3_cnt_en", n_cnt, 6);
        check_eq("n3_run_cycles", run_cycles, 6);

        // N=0, downstream holds off 3 cycles
        run_job(0, -1, 0, 3, 0, 0, lat);
        check_eq("n0_latency", lat, 1);
        check_eq("n0_saves", n_save, 0);
        check_eq("n0_out_valid_cycles", n_ov, 4);
        check_eq("n0_acc_clear", n_clear, 0);
        check_eq("n0_run_cycles", run_cycles, 0);

        // Watchdog: row array never reports done
        tie0 = 1'b1;
        mags[0] = 5; mags[1] = 5;
        run_job(2, -1, 0, 0, 0, 0, lat);
        tie0 = 1'b0;
        check_eq("wd_err", err, 1);
        check_eq("wd_run_cycles", run_cycles, 129);
        check_eq("wd_cnt_en", n_cnt, 129);
        check_eq("wd_saves", n_save, 1);
        check_eq("wd_out_valid", n_ov, 1);

        // Reset in IDLE clears a set err
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_reset_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Watchdog again, then the next accepted start clears err
        tie0 = 1'b1;
        run_job(1, -1, 0, 0, 0, 0, lat);
        tie0 = 1'b0;
        check_eq("wd2_err", err, 1);
        run_job(0, -1, 0, 0, 0, 0, lat);
        check_eq("after_wd_err", err, 0);
        check_eq("after_wd_latency", lat, 1);

        // Abort coincident with row_done on the last pair
        mags[0] = 1; mags[1] = 2;
        run_job(2, -1, 0, 0, 1, 0, lat);
        check_eq("abort_hit", abort_hit, 1);
        check_eq("abort_out_valid", n_ov, 0);
        check_eq("abort_start_ready", start_ready, 1);
        check_eq("abort_err", err, 0);
        check_eq("abort_cnt_en", n_cnt, 5);

        // Reset mid-RUN with vec_idx=2
        mags[0] = 1; mags[1] = 1; mags[2] = 3; mags[3] = 3;
        run_job(4, -1, 0, 0, 0, 1, lat);
        check_eq("mid_reset_hit", reset_hit, 1);

        // num_vec above MAX_VEC is clamped
        foreach (mags[i]) mags[i] = 0;
        run_job(20, -1, 0, 0, 0, 0, lat);
        check_eq("clamp_saves", n_save, 16);
        check_eq("clamp_run_cycles", run_cycles, 16);
        check_eq("clamp_last_idx", (save_idx.size() > 15) ? save_idx[15] : -1, 15);

        // Largest legal magnitude: row_done lands on the watchdog limit cycle and wins
        mags[0] = 128;
        run_job(1, -1, 0, 0, 0, 0, lat);
        check_eq("maxmag_run_cycles", run_cycles, 129);
        check_eq("maxmag_err", err, 0);
        check_eq("maxmag_out_valid", n_ov, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
